// File: rtl/tma_pkg.sv
// Shared types for the TMA slot-accounting monitor: read-map codes, FSM states, status layout.
package tma_pkg;

    localparam int NUM_LIVE_CNT      = 7;
    localparam int STATUS_OVF_LSB    = 0;
    localparam int STATUS_FROZEN_BIT = 8;

    typedef enum logic [3:0] {
        ADDR_TOTAL     = 4'd0,
        ADDR_INSTR     = 4'd1,
        ADDR_BUBBLE    = 4'd2,
        ADDR_FRONTEND  = 4'd3,
        ADDR_BACKEND   = 4'd4,
        ADDR_RETIRE    = 4'd5,
        ADDR_FLUSH     = 4'd6,
        ADDR_BAD_SPEC  = 4'd7,
        ADDR_FLUSH_REC = 4'd8,
        ADDR_FE_ADJ    = 4'd9,
        ADDR_STATUS    = 4'd10
    } tma_addr_e;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_FROZEN = 1'b1
    } tma_state_e;

endpackage

// File: rtl/tma_perf_monitor_if.sv
// Core event taps, counter control and the CSR-style read port of the TMA monitor.
interface tma_perf_monitor_if #(parameter int CNT_W = 64);

    logic             dec0_vld;
    logic             dec1_vld;
    logic             backend_stall;
    logic             flush_pipe;
    logic             retire0;
    logic             retire1;
    logic             cnt_freeze;
    logic             cnt_clr;
    logic             snap_req;
    logic             rd_en;
    logic [3:0]       rd_addr;
    logic             rd_vld;
    logic [CNT_W-1:0] rd_data;
    logic             rd_err;

    modport master (
        output dec0_vld, dec1_vld, backend_stall, flush_pipe, retire0, retire1,
        output cnt_freeze, cnt_clr, snap_req, rd_en, rd_addr,
        input  rd_vld, rd_data, rd_err
    );

    modport slave (
        input  dec0_vld, dec1_vld, backend_stall, flush_pipe, retire0, retire1,
        input  cnt_freeze, cnt_clr, snap_req, rd_en, rd_addr,
        output rd_vld, rd_data, rd_err
    );

endinterface

// File: rtl/tma_sat_counter.sv
// Saturating event counter: adds 0..SLOTS per enabled cycle, pins at all-ones with a sticky ovf.
// One-cycle update; clr wins over en and zeroes both count and ovf.
module tma_sat_counter #(
    parameter int CNT_W = 64,
    parameter int INC_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [INC_W-1:0] inc,
    output logic [CNT_W-1:0] cnt,
    output logic             ovf
);

    localparam logic [CNT_W:0] MAX = {1'b0, {CNT_W{1'b1}}};

    logic [CNT_W:0] sum;

    always_comb begin
        sum = {1'b0, cnt} + {{(CNT_W + 1 - INC_W){1'b0}}, inc};
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
            ovf <= 1'b0;
        end else if (en) begin
            if (sum >= MAX) begin
                cnt <= '1;
                ovf <= 1'b1;
            end else begin
                cnt <= sum[CNT_W-1:0];
            end
        end
    end

endmodule

// File: rtl/tma_perf_monitor.sv
// Top-down slot accounting for the 2-wide core: live saturating counters, snapshot shadow set,
// derived metrics and a registered read port (data 1 cycle after rd_en, no backpressure).
module tma_perf_monitor
    import tma_pkg::*;
#(
    parameter int CNT_W       = 64,
    parameter int SLOTS       = 2,
    parameter int FLUSH_SLOTS = 8
) (
    input logic               clk,
    input logic               rst,
    tma_perf_monitor_if.slave bus
);

    localparam int INC_W = $clog2(SLOTS + 1);
    localparam int FR_W  = CNT_W + $clog2(FLUSH_SLOTS) + 1;

    tma_state_e       state;
    logic             cnt_en;
    logic [INC_W-1:0] dec_cnt;
    logic [INC_W-1:0] inc    [NUM_LIVE_CNT];
    logic [CNT_W-1:0] live   [NUM_LIVE_CNT];
    logic [CNT_W-1:0] shadow [NUM_LIVE_CNT];
    logic [NUM_LIVE_CNT-1:0] ovf;

    logic [FR_W-1:0]  flush_prod;
    logic [CNT_W-1:0] flush_rec;
    logic [CNT_W-1:0] bad_spec;
    logic [CNT_W-1:0] frontend_adj;
    logic [CNT_W-1:0] status;
    logic [CNT_W-1:0] rd_mux;
    logic             rd_bad;

    // Freeze gates events combinationally in the same cycle; state only feeds the status word.
    assign cnt_en = !bus.cnt_freeze;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_RUN;
        end else begin
            case (state)
                ST_RUN:    if (bus.cnt_freeze)  state <= ST_FROZEN;
                ST_FROZEN: if (!bus.cnt_freeze) state <= ST_RUN;
                default:   state <= ST_RUN;
            endcase
        end
    end

    // Counter index order equals read-map codes 0..6.
    always_comb begin
        dec_cnt = INC_W'(bus.dec0_vld) + INC_W'(bus.dec1_vld);
        inc[0]  = INC_W'(SLOTS);
        inc[1]  = dec_cnt;
        inc[2]  = INC_W'(!bus.dec0_vld) + INC_W'(!bus.dec1_vld);
        inc[3]  = bus.backend_stall ? '0 : dec_cnt;
        inc[4]  = bus.backend_stall ? dec_cnt : '0;
        inc[5]  = INC_W'(bus.retire0) + INC_W'(bus.retire1);
        inc[6]  = INC_W'(bus.flush_pipe);
    end

    for (genvar i = 0; i < NUM_LIVE_CNT; i++) begin : g_cnt
        tma_sat_counter #(.CNT_W(CNT_W), .INC_W(INC_W)) u_cnt (
            .clk (clk),
            .rst (rst),
            .clr (bus.cnt_clr),
            .en  (cnt_en),
            .inc (inc[i]),
            .cnt (live[i]),
            .ovf (ovf[i])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_LIVE_CNT; i++) shadow[i] <= '0;
        end else if (bus.snap_req) begin
            for (int i = 0; i < NUM_LIVE_CNT; i++) shadow[i] <= live[i];
        end
    end

    always_comb begin
        flush_prod   = FR_W'(shadow[6]) * FR_W'(FLUSH_SLOTS);
        flush_rec    = (|flush_prod[FR_W-1:CNT_W]) ? '1 : flush_prod[CNT_W-1:0];
        bad_spec     = (shadow[1] >= shadow[5]) ? shadow[1] - shadow[5] : '0;
        frontend_adj = (shadow[3] >= flush_rec) ? shadow[3] - flush_rec : '0;
        status       = '0;
        status[STATUS_OVF_LSB +: NUM_LIVE_CNT] = ovf;
        status[STATUS_FROZEN_BIT]              = (state == ST_FROZEN);
    end

    always_comb begin
        rd_mux = '0;
        rd_bad = 1'b0;
        case (bus.rd_addr)
            ADDR_TOTAL:     rd_mux = shadow[0];
            ADDR_INSTR:     rd_mux = shadow[1];
            ADDR_BUBBLE:    rd_mux = shadow[2];
            ADDR_FRONTEND:  rd_mux = shadow[3];
            ADDR_BACKEND:   rd_mux = shadow[4];
            ADDR_RETIRE:    rd_mux = shadow[5];
            ADDR_FLUSH:     rd_mux = shadow[6];
            ADDR_BAD_SPEC:  rd_mux = bad_spec;
            ADDR_FLUSH_REC: rd_mux = flush_rec;
            ADDR_FE_ADJ:    rd_mux = frontend_adj;
            ADDR_STATUS:    rd_mux = status;
            default:        rd_bad = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.rd_vld  <= 1'b0;
            bus.rd_data <= '0;
            bus.rd_err  <= 1'b0;
        end else begin
            bus.rd_vld  <= bus.rd_en;
            bus.rd_data <= bus.rd_en ? rd_mux : '0;
            bus.rd_err  <= bus.rd_en && rd_bad;
        end
    end

endmodule

// File: tb/tb_tma_perf_monitor.sv
// Directed bench for tma_perf_monitor: a 64-bit instance plus a 12-bit instance for saturation.
module tb_tma_perf_monitor;
    import tma_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, dec0, dec1, stall, flush, ret0, ret1, freeze, clr, snap, rd_en;
    logic [3:0] rd_addr;

    tma_perf_monitor_if #(.CNT_W(64)) mbus ();
    tma_perf_monitor_if #(.CNT_W(12)) sbus ();

    assign mbus.dec0_vld = dec0;   assign sbus.dec0_vld = dec0;
    assign mbus.dec1_vld = dec1;   assign sbus.dec1_vld = dec1;
    assign mbus.backend_stall = stall; assign sbus.backend_stall = stall;
    assign mbus.flush_pipe = flush; assign sbus.flush_pipe = flush;
    assign mbus.retire0 = ret0;    assign sbus.retire0 = ret0;
    assign mbus.retire1 = ret1;    assign sbus.retire1 = ret1;
    assign mbus.cnt_freeze = freeze; assign sbus.cnt_freeze = freeze;
    assign mbus.cnt_clr = clr;     assign sbus.cnt_clr = clr;
    assign mbus.snap_req = snap;   assign sbus.snap_req = snap;
    assign mbus.rd_en = rd_en;     assign sbus.rd_en = rd_en;
    assign mbus.rd_addr = rd_addr; assign sbus.rd_addr = rd_addr;

    tma_perf_monitor #(.CNT_W(64), .SLOTS(2), .FLUSH_SLOTS(8)) dut (
        .clk (clk), .rst (rst), .bus (mbus)
    );
    tma_perf_monitor #(.CNT_W(12), .SLOTS(2), .FLUSH_SLOTS(8)) dut_sat (
        .clk (clk), .rst (rst), .bus (sbus)
    );

    typedef struct {
        string       name;
        bit          sel;      // 0: 64-bit instance, 1: 12-bit instance
        logic [3:0]  addr;
        logic [63:0] exp_data;
        logic        exp_err;
    } rd_vec_t;

    rd_vec_t tbl[$];
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n, input logic d0, input logic d1, input logic st);
        dec0 = d0; dec1 = d1; stall = st;
        repeat (n) tick();
        dec0 = 1'b0; dec1 = 1'b0; stall = 1'b0;
    endtask

    task automatic snap_cycle();
        snap = 1'b1; tick(); snap = 1'b0;
    endtask

    task automatic clr_cycle();
        clr = 1'b1; tick(); clr = 1'b0;
    endtask

    function automatic void add(input string name, input bit sel, input logic [3:0] addr,
                                input logic [63:0] data, input logic err);
        rd_vec_t v;
        v.name = name; v.sel = sel; v.addr = addr; v.exp_data = data; v.exp_err = err;
        tbl.push_back(v);
    endfunction

    // Issues the queued reads back to back and checks each result the cycle after its rd_en.
    task automatic run_table();
        logic        vld, err;
        logic [63:0] data;
        foreach (tbl[i]) begin
            rd_en = 1'b1;
            rd_addr = tbl[i].addr;
            tick();
            vld  = tbl[i].sel ? sbus.rd_vld : mbus.rd_vld;
            err  = tbl[i].sel ? sbus.rd_err : mbus.rd_err;
            data = tbl[i].sel ? {52'd0, sbus.rd_data} : mbus.rd_data;
            check({tbl[i].name, "_vld"}, vld, 1'b1);
            check(tbl[i].name, data, tbl[i].exp_data);
            check({tbl[i].name, "_err"}, err, tbl[i].exp_err);
        end
        rd_en = 1'b0;
        tick();
        check("rd_vld_idle", mbus.rd_vld, 1'b0);
        tbl.delete();
    endtask

    initial begin
        rst = 1'b1; dec0 = 0; dec1 = 0; stall = 0; flush = 0; ret0 = 0; ret1 = 0;
        freeze = 0; clr = 0; snap = 0; rd_en = 0; rd_addr = 4'd0;
        repeat (3) tick();
        check("reset_rd_vld", mbus.rd_vld, 1'b0);
        check("reset_rd_data", mbus.rd_data, 64'd0);
        check("reset_rd_err", mbus.rd_err, 1'b0);
        rst = 1'b0;

        // 1: full-width decode, no stall
        run(10, 1'b1, 1'b1, 1'b0);
        snap_cycle();
        rd_en = 1'b1; rd_addr = 4'd0;
        #1 check("t1_vld_not_early", mbus.rd_vld, 1'b0);
        tick();
        check("t1_vld_late", mbus.rd_vld, 1'b1);
        check("t1_total_first", mbus.rd_data, 64'd20);
        rd_en = 1'b0;
        add("t1_total", 0, 4'd0, 64'd20, 0);
        add("t1_instr", 0, 4'd1, 64'd20, 0);
        add("t1_frontend", 0, 4'd3, 64'd20, 0);
        add("t1_bubble", 0, 4'd2, 64'd0, 0);
        add("t1_backend", 0, 4'd4, 64'd0, 0);
        add("t1_bad_spec", 0, 4'd7, 64'd20, 0);
        add("t1_fe_adj", 0, 4'd9, 64'd20, 0);
        run_table();

        // 2: half-width decode under backend stall, two retires
        clr_cycle();
        ret0 = 1'b1;
        run(2, 1'b1, 1'b0, 1'b1);
        ret0 = 1'b0;
        run(2, 1'b1, 1'b0, 1'b1);
        snap_cycle();
        add("t2_backend", 0, 4'd4, 64'd4, 0);
        add("t2_bubble", 0, 4'd2, 64'd4, 0);
        add("t2_retire", 0, 4'd5, 64'd2, 0);
        add("t2_bad_spec", 0, 4'd7, 64'd2, 0);
        add("t2_total", 0, 4'd0, 64'd8, 0);
        add("t2_frontend", 0, 4'd3, 64'd0, 0);
        run_table();

        // 3: flush recovery, clamp then positive adjustment
        clr_cycle();
        run(5, 1'b1, 1'b1, 1'b0);
        flush = 1'b1;
        repeat (3) tick();
        flush = 1'b0;
        snap_cycle();
        add("t3_frontend", 0, 4'd3, 64'd10, 0);
        add("t3_flush", 0, 4'd6, 64'd3, 0);
        add("t3_flush_rec", 0, 4'd8, 64'd24, 0);
        add("t3_fe_adj_clamp", 0, 4'd9, 64'd0, 0);
        add("t3_total", 0, 4'd0, 64'd16, 0);
        add("t3_bubble", 0, 4'd2, 64'd6, 0);
        run_table();
        run(10, 1'b1, 1'b1, 1'b0);
        snap_cycle();
        add("t3_frontend30", 0, 4'd3, 64'd30, 0);
        add("t3_fe_adj6", 0, 4'd9, 64'd6, 0);
        add("t3_flush_rec2", 0, 4'd8, 64'd24, 0);
        run_table();

        // 5: snap and clear in one cycle, then a read racing a second snap
        clr_cycle();
        run(20, 1'b1, 1'b1, 1'b0);
        dec0 = 1'b1; dec1 = 1'b1; snap = 1'b1; clr = 1'b1;
        tick();
        dec0 = 1'b0; dec1 = 1'b0; clr = 1'b0;
        rd_en = 1'b1; rd_addr = 4'd0;
        tick();
        check("t5_read_old_shadow", mbus.rd_data, 64'd40);
        snap = 1'b0; rd_en = 1'b0;
        add("t5_total_after_clr", 0, 4'd0, 64'd0, 0);
        add("t5_instr_after_clr", 0, 4'd1, 64'd0, 0);
        run_table();

        // 6: freeze with traffic, status, unmapped addresses
        clr_cycle();
        run(3, 1'b1, 1'b1, 1'b0);
        freeze = 1'b1; dec0 = 1'b1; dec1 = 1'b1; flush = 1'b1; ret0 = 1'b1;
        repeat (2) tick();
        rd_en = 1'b1; rd_addr = 4'd10;
        tick();
        check("t6_status_frozen", mbus.rd_data, 64'h100);
        rd_en = 1'b0;
        repeat (2) tick();
        freeze = 1'b0; dec0 = 1'b0; dec1 = 1'b0; flush = 1'b0; ret0 = 1'b0;
        snap_cycle();
        add("t6_total", 0, 4'd0, 64'd6, 0);
        add("t6_instr", 0, 4'd1, 64'd6, 0);
        add("t6_retire", 0, 4'd5, 64'd0, 0);
        add("t6_flush", 0, 4'd6, 64'd0, 0);
        add("t6_status_run", 0, 4'd10, 64'd0, 0);
        add("t6_addr12", 0, 4'd12, 64'd0, 1);
        add("t6_addr15", 0, 4'd15, 64'd0, 1);
        run_table();

        // Reset while a read is in flight
        rd_en = 1'b1; rd_addr = 4'd0;
        tick();
        rst = 1'b1;
        tick();
        check("rst_kills_read_vld", mbus.rd_vld, 1'b0);
        check("rst_kills_read_data", mbus.rd_data, 64'd0);
        rd_en = 1'b0;
        tick();
        rst = 1'b0;

        // 4: saturation on the 12-bit instance (all-ones = 0xFFF)
        run(2047, 1'b1, 1'b1, 1'b0);
        run(1, 1'b1, 1'b0, 1'b0);
        snap_cycle();
        add("t4_instr_sat", 1, 4'd1, 64'hFFF, 0);
        add("t4_total_sat", 1, 4'd0, 64'hFFF, 0);
        add("t4_frontend_sat", 1, 4'd3, 64'hFFF, 0);
        add("t4_bubble", 1, 4'd2, 64'd1, 0);
        add("t4_status_ovf", 1, 4'd10, 64'h00B, 0);
        run_table();
        run(1, 1'b1, 1'b1, 1'b0);
        snap_cycle();
        add("t4_no_wrap", 1, 4'd1, 64'hFFF, 0);
        run_table();
        clr_cycle();
        snap_cycle();
        add("t4_instr_cleared", 1, 4'd1, 64'd0, 0);
        add("t4_status_cleared", 1, 4'd10, 64'd0, 0);
        run_table();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
